reg8_bank_rd: RTL
=================

REG8_BANK_RD -- requirements
Module: reg8_bank_rd

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of storage words; ADDR_W = log2(DEPTH) = 3.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_N  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe; writes in[] to the word at wr_addr on the rising clock edge.
REQ-006 wr_addr  input  ADDR_W  write address.
REQ-007 in  input  WIDTH  write data.
REQ-008 rd_req  input  1  start a burst read; sampled only in IDLE.
REQ-009 rd_addr  input  ADDR_W  burst start address, captured with rd_req.
REQ-010 rd_len  input  ADDR_W  burst length minus one (0 means 1 word, 7 means 8 words), captured with rd_req.
REQ-011 rd_ready  input  1  consumer accepts the current word.
REQ-012 rd_valid  output  1  out[] holds a valid burst word.
REQ-013 out  output  WIDTH  registered read data.
REQ-014 rd_busy  output  1  high while a burst is in progress (state BURST).

Function
REQ-015 Storage SHALL be DEPTH words of WIDTH bits; any wr_en=1 edge SHALL update mem[wr_addr] in both states.
REQ-016 The FSM SHALL have two states: IDLE (rd_busy=0, rd_valid=0) and BURST (rd_busy=1, rd_valid=1).
REQ-017 IDLE with rd_req=1 at an edge: ptr<=rd_addr, cnt<=rd_len, out<=word(rd_addr), state<=BURST; rd_valid is high in the next cycle (1-cycle latency).
REQ-018 word(a) SHALL equal in[] when wr_en=1 and wr_addr==a on the same edge (write-through bypass), else mem[a].
REQ-019 BURST with rd_ready=1 and cnt!=0: ptr<=ptr+1 mod DEPTH (wraps 7->0), cnt<=cnt-1, out<=word(ptr+1).
REQ-020 BURST with rd_ready=1 and cnt==0: state<=IDLE, rd_valid low next cycle, out holds last word.
REQ-021 BURST with rd_ready=0: out, ptr, cnt and rd_valid SHALL hold; a write to the held word's address SHALL NOT change out (snapshot semantics).
REQ-022 rd_req in BURST SHALL be ignored; no queuing.
REQ-023 Exactly rd_len+1 handshakes (rd_valid&rd_ready) SHALL occur per burst; back-to-back rd_ready=1 yields one word per cycle.
REQ-024 In IDLE out SHALL hold its last value.

Reset
REQ-025 reset_N=0 SHALL immediately, without a clock edge: clear all storage words to 0x00, state<=IDLE, out<=0x00, rd_valid=0, rd_busy=0, ptr=0, cnt=0.
REQ-026 Reset mid-burst SHALL abort the burst; no further words are delivered after reset_N returns high.
REQ-027 Writes and rd_req presented while reset_N=0 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold WIDTH, DEPTH, ADDR_W defaults and the state encoding (IDLE=0, BURST=1).
REQ-029 Each storage word SHALL be one instance of the existing reg8_ner register (clock, reset_N, wr_en, in, out), write enable decoded from wr_en and wr_addr.
REQ-030 Read mux, bypass, FSM and output register SHALL live in reg8_bank_rd.

Verification
REQ-031 Write 0xAA@0, 0x99@1, 0x55@2; rd_req, rd_addr=0, rd_len=2, rd_ready=1 -> out 0xAA, 0x99, 0x55 on three consecutive valid cycles, then rd_valid=0.
REQ-032 Pre-load mem[7]=0x11, mem[0]=0xFF; burst rd_addr=7, rd_len=1 -> out 0x11 then 0xFF (wrap).
REQ-033 Burst rd_addr=0, rd_len=0, rd_ready=0 for 4 cycles while writing 0x55@0 -> out holds 0xAA, rd_valid stays 1; rd_ready=1 -> IDLE next cycle.
REQ-034 rd_req with wr_en=1, wr_addr=rd_addr=3, in=0x99 on same edge -> first out is 0x99.
REQ-035 reset_N low mid-burst between clock edges -> out=0x00, rd_valid=0, rd_busy=0 at once; subsequent read of any address returns 0x00.
REQ-036 rd_req pulsed during BURST -> ignored; handshake count equals original rd_len+1.

Source files
------------

// File: rtl/reg8_bank_rd_pkg.sv
// reg8_bank_rd_pkg: shared sizes and burst-read FSM encoding
package reg8_bank_rd_pkg;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;
endpackage

// File: rtl/reg8_ner.sv
// reg8_ner: WIDTH-bit register with write enable and async active-low clear
module reg8_ner #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  // load on enable, clear on reset
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) out <= '0;
    else if (wr_en) out <= in;
endmodule

// File: rtl/reg8_bank_rd.sv
// reg8_bank_rd: register bank with burst read port, write-through bypass and snapshot output
module reg8_bank_rd
  import reg8_bank_rd_pkg::*;
#(
  parameter int  WIDTH  = reg8_bank_rd_pkg::WIDTH,
  parameter int  DEPTH  = reg8_bank_rd_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  out,
  output logic              rd_busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, ptr_inc, rd_sel;
  logic [WIDTH-1:0]  out_q, out_d, word;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              take, step, last;

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_word
    reg8_ner #(.WIDTH(WIDTH)) u_word (
      .clock  (clock),
      .reset_N(reset_N),
      .wr_en  (wr_en && wr_addr == ADDR_W'(g)),
      .in     (in),
      .out    (mem[g])
    );
  end

  assign ptr_inc = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign rd_sel  = (state_q == IDLE) ? rd_addr : ptr_inc;
  assign word    = (wr_en && wr_addr == rd_sel) ? in : mem[rd_sel];
  assign take    = state_q == IDLE && rd_req;
  assign step    = state_q == BURST && rd_ready && cnt_q != '0;
  assign last    = state_q == BURST && rd_ready && cnt_q == '0;
  assign out     = out_q;

  // state register
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) state_q <= IDLE;
    else state_q <= state_d;

  // next state: start on request in IDLE, finish on the last accepted word
  always_comb state_d = take ? BURST : last ? IDLE : state_q;

  // burst pointer, remaining count and output word; all hold while the consumer stalls
  always_comb begin
    ptr_d = take ? rd_addr : step ? ptr_inc : ptr_q;
    cnt_d = take ? rd_len : step ? cnt_q - 1'b1 : cnt_q;
    out_d = (take || step) ? word : out_q;
  end

  // datapath registers
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      ptr_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end

  // status outputs follow the state directly
  always_comb begin
    rd_busy  = state_q == BURST;
    rd_valid = state_q == BURST;
  end
endmodule
